// File: rtl/hex_scan_display.sv
// Time-multiplexed seven-segment scanner: double-buffered hex word, per-digit
// enable/dp masks, one digit per slot with leading anti-ghost blanking.
module hex_scan_display #(
  parameter int DIGITS       = 8,
  parameter int CLK_DIV      = 100000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  load,
  output logic [6:0]            hex,
  output logic                  hex_dp,
  output logic [DIGITS-1:0]     hex_on,
  output logic                  frame_done,
  output logic                  busy
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [CW-1:0]       count_q, count_d;
  logic [IW-1:0]       index_q, index_d;
  logic [4*DIGITS-1:0] pend_data_q, pend_data_d, disp_data_q, disp_data_d;
  logic [DIGITS-1:0]   pend_en_q, pend_en_d, disp_en_q, disp_en_d;
  logic [DIGITS-1:0]   pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
  logic                busy_q, busy_d;
  logic                frame_done_q, frame_done_d;
  logic [6:0]          hex_q, hex_d;
  logic                hex_dp_q, hex_dp_d;
  logic [DIGITS-1:0]   hex_on_q, hex_on_d;

  logic                slot_end, wrap;
  logic [3:0]          cur_nib;
  logic                cur_en, cur_dp;

  function automatic logic [6:0] enc(input logic [3:0] n);
    case (n)
      4'h0: enc = 7'h40;
      4'h1: enc = 7'h79;
      4'h2: enc = 7'h24;
      4'h3: enc = 7'h30;
      4'h4: enc = 7'h19;
      4'h5: enc = 7'h12;
      4'h6: enc = 7'h02;
      4'h7: enc = 7'h78;
      4'h8: enc = 7'h00;
      4'h9: enc = 7'h10;
      4'hA: enc = 7'h08;
      4'hB: enc = 7'h03;
      4'hC: enc = 7'h46;
      4'hD: enc = 7'h21;
      4'hE: enc = 7'h06;
      default: enc = 7'h0E;
    endcase
  endfunction

  always_comb begin
    slot_end = (count_q == CNT_LAST);
    wrap     = slot_end && (index_q == IDX_LAST);

    count_d = slot_end ? '0 : count_q + 1'b1;
    index_d = index_q;
    if (slot_end) index_d = (index_q == IDX_LAST) ? '0 : index_q + 1'b1;
    frame_done_d = wrap;

    pend_data_d = pend_data_q;
    pend_en_d   = pend_en_q;
    pend_dp_d   = pend_dp_q;
    disp_data_d = disp_data_q;
    disp_en_d   = disp_en_q;
    disp_dp_d   = disp_dp_q;
    busy_d      = busy_q;
    // A load landing on the wrap bypasses the pending stage entirely.
    if (wrap && load) begin
      disp_data_d = data;
      disp_en_d   = digit_en;
      disp_dp_d   = dp;
      busy_d      = 1'b0;
    end else if (wrap && busy_q) begin
      disp_data_d = pend_data_q;
      disp_en_d   = pend_en_q;
      disp_dp_d   = pend_dp_q;
      busy_d      = 1'b0;
    end else if (load) begin
      pend_data_d = data;
      pend_en_d   = digit_en;
      pend_dp_d   = dp;
      busy_d      = 1'b1;
    end

    cur_nib = '0;
    cur_en  = 1'b0;
    cur_dp  = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (index_q == IW'(i)) begin
        cur_nib = disp_data_q[4*i +: 4];
        cur_en  = disp_en_q[i];
        cur_dp  = disp_dp_q[i];
      end
    end

    hex_on_d = '1;
    hex_d    = 7'h7F;
    hex_dp_d = 1'b1;
    if (int'(count_q) >= BLANK_CYCLES) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (index_q == IW'(i)) hex_on_d[i] = ~cur_en;
      end
      if (cur_en) hex_d = enc(cur_nib);
      hex_dp_d = ~(cur_dp & cur_en);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q      <= '0;
      index_q      <= '0;
      pend_data_q  <= '0;
      pend_en_q    <= '0;
      pend_dp_q    <= '0;
      disp_data_q  <= '0;
      disp_en_q    <= '0;
      disp_dp_q    <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      hex_q        <= 7'h7F;
      hex_dp_q     <= 1'b1;
      hex_on_q     <= '1;
    end else begin
      count_q      <= count_d;
      index_q      <= index_d;
      pend_data_q  <= pend_data_d;
      pend_en_q    <= pend_en_d;
      pend_dp_q    <= pend_dp_d;
      disp_data_q  <= disp_data_d;
      disp_en_q    <= disp_en_d;
      disp_dp_q    <= disp_dp_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      hex_q        <= hex_d;
      hex_dp_q     <= hex_dp_d;
      hex_on_q     <= hex_on_d;
    end
  end

  assign hex        = hex_q;
  assign hex_dp     = hex_dp_q;
  assign hex_on     = hex_on_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_hex_scan_display.sv
// Directed bench for hex_scan_display: an 8-digit instance with short slots
// and a single-digit instance without blanking.
module tb_hex_scan_display;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] data;
  logic [7:0]  digit_en, dp;
  logic        load;
  logic [6:0]  hex;
  logic        hex_dp;
  logic [7:0]  hex_on;
  logic        frame_done, busy;

  logic [3:0]  data1;
  logic        en1, dp1, load1;
  logic [6:0]  hex1;
  logic        hex_dp1, hex_on1, fd1, busy1;

  int errors = 0;
  int checks = 0;

  hex_scan_display #(.DIGITS(8), .CLK_DIV(4), .BLANK_CYCLES(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .data(data), .digit_en(digit_en), .dp(dp),
    .load(load), .hex(hex), .hex_dp(hex_dp), .hex_on(hex_on),
    .frame_done(frame_done), .busy(busy)
  );

  hex_scan_display #(.DIGITS(1), .CLK_DIV(2), .BLANK_CYCLES(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .data(data1), .digit_en(en1), .dp(dp1),
    .load(load1), .hex(hex1), .hex_dp(hex_dp1), .hex_on(hex_on1),
    .frame_done(fd1), .busy(busy1)
  );

  function automatic logic [6:0] seg(input logic [3:0] n);
    logic [6:0] t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[n];
  endfunction

  // Expected {hex_on, hex, hex_dp, frame_done} j+1 clocks after a frame wrap.
  function automatic logic [16:0] exp_vec(input logic [31:0] d, input logic [7:0] en,
                                          input logic [7:0] p, input int j);
    int         s  = j / 4;
    int         c  = j % 4;
    logic [7:0] on = 8'hFF;
    logic [6:0] h  = 7'h7F;
    logic       pd = 1'b1;
    if (c >= 1) begin
      on[s] = ~en[s];
      if (en[s]) h = seg(d[4*s +: 4]);
      pd = ~(p[s] & en[s]);
    end
    return {on, h, pd, (j == 31)};
  endfunction

  task automatic pulse_load(input logic [31:0] d, input logic [7:0] e, input logic [7:0] p);
    data = d; digit_en = e; dp = p; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic sync_frame();
    int n = 0;
    @(negedge clk);
    while (frame_done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL sync_frame timeout: frame_done=%b want 1", frame_done);
    end
  endtask

  task automatic test_reset();
    int n;
    logic [16:0] obs;
    pulse_load(32'h76543210, 8'hFF, 8'h01);
    sync_frame();
    repeat (13) @(negedge clk);
    pulse_load(32'hFFFF_FFFF, 8'hFF, 8'h01);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL reset_pre_busy got %b want 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    obs = {hex_on, hex, hex_dp, frame_done};
    checks++;
    if (obs !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
      errors++; $display("FAIL reset_outputs got %h want %h", obs, {8'hFF, 7'h7F, 1'b1, 1'b0});
    end
    checks++;
    if ({busy, hex_on1, busy1} !== 3'b010) begin
      errors++; $display("FAIL reset_busy_u1 got %b want 010", {busy, hex_on1, busy1});
    end
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (frame_done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 32) begin errors++; $display("FAIL reset_restart clocks to first wrap got %0d want 32", n); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_discard busy got %b want 0", busy); end
    for (int j = 0; j < 32; j++) begin
      @(negedge clk);
      obs = {hex_on, hex, hex_dp, frame_done};
      checks++;
      if (obs !== exp_vec(32'h0, 8'h00, 8'h00, j)) begin
        errors++; $display("FAIL reset_blank j=%0d got %h want %h", j, obs, exp_vec(32'h0, 8'h00, 8'h00, j));
      end
    end
  endtask

  task automatic test_full_scan();
    logic [16:0] obs;
    pulse_load(32'h76543210, 8'hFF, 8'h01);
    sync_frame();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL scan_busy got %b want 0", busy); end
    for (int j = 0; j < 32; j++) begin
      @(negedge clk);
      obs = {hex_on, hex, hex_dp, frame_done};
      checks++;
      if (obs !== exp_vec(32'h76543210, 8'hFF, 8'h01, j)) begin
        errors++; $display("FAIL full_scan j=%0d got %h want %h", j, obs, exp_vec(32'h76543210, 8'hFF, 8'h01, j));
      end
    end
  endtask

  task automatic test_tear_free();
    logic [16:0] obs;
    for (int j = 0; j < 32; j++) begin
      @(negedge clk);
      obs = {hex_on, hex, hex_dp, frame_done};
      checks++;
      if (obs !== exp_vec(32'h76543210, 8'hFF, 8'h01, j)) begin
        errors++; $display("FAIL tear_old j=%0d got %h want %h", j, obs, exp_vec(32'h76543210, 8'hFF, 8'h01, j));
      end
      if (j == 10) begin data = 32'hFFFF_FFFF; load = 1'b1; end
      if (j == 11) begin
        load = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL tear_busy_set got %b want 1", busy); end
      end
      if (j == 31) begin
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL tear_busy_clear got %b want 0", busy); end
      end
    end
    for (int j = 0; j < 32; j++) begin
      @(negedge clk);
      obs = {hex_on, hex, hex_dp, frame_done};
      checks++;
      if (obs !== exp_vec(32'hFFFF_FFFF, 8'hFF, 8'h01, j)) begin
        errors++; $display("FAIL tear_new j=%0d got %h want %h", j, obs, exp_vec(32'hFFFF_FFFF, 8'hFF, 8'h01, j));
      end
    end
  endtask

  task automatic test_double_and_wrap_load();
    logic [16:0] obs;
    logic [31:0] cur;
    cur = 32'hFFFF_FFFF;
    for (int f = 0; f < 3; f++) begin
      for (int j = 0; j < 32; j++) begin
        @(negedge clk);
        obs = {hex_on, hex, hex_dp, frame_done};
        checks++;
        if (obs !== exp_vec(cur, 8'hFF, 8'h01, j)) begin
          errors++; $display("FAIL dbl_wrap f=%0d j=%0d got %h want %h", f, j, obs, exp_vec(cur, 8'hFF, 8'h01, j));
        end
        if (f == 0 && j == 5) begin data = 32'hAAAA_AAAA; load = 1'b1; end
        if (f == 0 && j == 6) data = 32'h89AB_CDEF;
        if (f == 0 && j == 7) begin
          load = 1'b0;
          checks++;
          if (busy !== 1'b1) begin errors++; $display("FAIL dbl_busy got %b want 1", busy); end
        end
        if (f == 1 && j == 30) begin data = 32'h0123_4567; load = 1'b1; end
        if (f == 1 && j == 31) begin
          load = 1'b0;
          checks++;
          if (busy !== 1'b0) begin errors++; $display("FAIL wrap_load_busy got %b want 0", busy); end
        end
      end
      cur = (f == 0) ? 32'h89AB_CDEF : 32'h0123_4567;
    end
  endtask

  task automatic test_masking();
    logic [16:0] obs;
    for (int j = 0; j < 32; j++) begin
      @(negedge clk);
      obs = {hex_on, hex, hex_dp, frame_done};
      checks++;
      if (obs !== exp_vec(32'h0123_4567, 8'hFF, 8'h01, j)) begin
        errors++; $display("FAIL mask_pre j=%0d got %h want %h", j, obs, exp_vec(32'h0123_4567, 8'hFF, 8'h01, j));
      end
      if (j == 0) begin data = 32'h1357_9BDF; digit_en = 8'b1010_1010; dp = 8'hFF; load = 1'b1; end
      if (j == 1) load = 1'b0;
    end
    for (int j = 0; j < 32; j++) begin
      @(negedge clk);
      obs = {hex_on, hex, hex_dp, frame_done};
      checks++;
      if (obs !== exp_vec(32'h1357_9BDF, 8'hAA, 8'hFF, j)) begin
        errors++; $display("FAIL masking j=%0d got %h want %h", j, obs, exp_vec(32'h1357_9BDF, 8'hAA, 8'hFF, j));
      end
    end
  endtask

  task automatic test_edge_params();
    int n = 0;
    logic [9:0] obs;
    data1 = 4'h5; en1 = 1'b1; dp1 = 1'b0; load1 = 1'b1;
    @(negedge clk);
    load1 = 1'b0;
    repeat (3) @(negedge clk);
    while (fd1 !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 20) begin errors++; $display("FAIL edge_sync timeout fd1=%b want 1", fd1); end
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      obs = {hex_on1, hex1, hex_dp1, fd1};
      checks++;
      if (obs !== {1'b0, 7'h12, 1'b1, (j % 2 == 1)}) begin
        errors++; $display("FAIL edge_params j=%0d got %h want %h", j, obs, {1'b0, 7'h12, 1'b1, (j % 2 == 1)});
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; data = '0; digit_en = '0; dp = '0;
    load1 = 1'b0; data1 = '0; en1 = 1'b0; dp1 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_full_scan();
    test_tear_free();
    test_double_and_wrap_load();
    test_masking();
    test_edge_params();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
